// File: rtl/dpram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpram_arb_pkg
// Purpose  : Shared types and helpers for the dpram_arb dual-port RAM.
//            State encoding for the clear/ready controller, read-during-write
//            mode constants and the byte-lane merge helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dpram_arb_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // One byte lane of a byte-enable write: keep the stored byte unless enabled.
  function automatic logic [7:0] be_merge_byte(input logic [7:0] old_byte,
                                               input logic [7:0] new_byte,
                                               input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_arb_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dpram_rd_pipe
// Purpose  : Read-return pipeline for one dpram_arb port. Delays the read
//            strobe by RD_LAT cycles (1 or 2) and holds the last returned
//            word on out_data between strobes.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_data   : read accepted this cycle and its data
//            out_valid / out_data : rvalid pulse and held read data
// Revision : 1.0 - initial release
// ============================================================================
module dpram_rd_pipe
  import dpram_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              r_v1;
  logic [DATA_W-1:0] r_d1;

  // Data register only loads on a valid read, so it doubles as the hold reg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) r_d1 <= in_data;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_v2;
      logic [DATA_W-1:0] r_d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign out_valid = r_v2;
      assign out_data  = r_d2;
    end else begin : g_lat1
      assign out_valid = r_v1;
      assign out_data  = r_d1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dpram_arb.sv
`default_nettype none
// ============================================================================
// Module   : dpram_arb
// Purpose  : Two-port (A/B) single-clock RAM with req/gnt/rvalid handshake,
//            byte enables, same-address write collision arbitration (A wins),
//            selectable read-during-write behaviour, RD_LAT of 1 or 2 and an
//            optional post-reset zero fill.
// Ports    : clk, rst (async, active-high), init_busy
//            x_req, x_we, x_addr, x_be, x_wdata  : request side (x = a, b)
//            x_gnt, x_rvalid, x_rdata            : response side
//            coll                                : B stalled by collision
//            coll_cnt, acc_cnt                   : only with DPRAM_ARB_STATS_EN
// Macro    : DPRAM_ARB_STATS_EN adds collision / accepted-transfer counters.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_arb
  import dpram_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = RDW_READ_FIRST,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_busy,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
`ifdef DPRAM_ARB_STATS_EN
  output logic [15:0]         coll_cnt,
  output logic [31:0]         acc_cnt,
`endif
  output logic                coll
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_ready;
  logic              w_stall_b;
  logic              w_a_wr, w_a_rd, w_b_wr, w_b_rd;
  logic [DATA_W-1:0] w_a_old, w_b_old, w_a_wnew, w_b_wnew;
  logic [DATA_W-1:0] w_a_rdval, w_b_rdval;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= (INIT_CLEAR != 0) ? CLEAR : READY;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    init_busy   = 1'b0;
    case (r_state)
      CLEAR: begin
        init_busy = 1'b1;
        if (&r_clr_addr) w_state_nxt = READY;
      end
      READY:   w_state_nxt = READY;
      default: w_state_nxt = READY;
    endcase
  end

  // ---------------------------------------------------------- arbitration
  // rst is folded in so grants stay low while reset is held even when the
  // clear sequence is disabled and the FSM already sits in READY.
  assign w_ready   = (r_state == READY) & ~rst;
  assign w_stall_b = a_req & b_req & a_we & b_we & (a_addr == b_addr);

  assign a_gnt = a_req & w_ready;
  assign b_gnt = b_req & w_ready & ~w_stall_b;
  assign coll  = b_req & w_ready & w_stall_b;

  assign w_a_wr = a_gnt & a_we;
  assign w_a_rd = a_gnt & ~a_we;
  assign w_b_wr = b_gnt & b_we;
  assign w_b_rd = b_gnt & ~b_we;

  // -------------------------------------------------------- memory array
  assign w_a_old = mem[a_addr];
  assign w_b_old = mem[b_addr];

  generate
    for (genvar i = 0; i < NB; i++) begin : g_lane
      assign w_a_wnew[8*i +: 8] = be_merge_byte(w_a_old[8*i +: 8], a_wdata[8*i +: 8], a_be[i]);
      assign w_b_wnew[8*i +: 8] = be_merge_byte(w_b_old[8*i +: 8], b_wdata[8*i +: 8], b_be[i]);
    end
  endgenerate

  // Both ports can only write the same word in one cycle if arbitration
  // failed, so the two write statements never target the same entry.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      mem[r_clr_addr] <= '0;
    end else begin
      if (w_a_wr) mem[a_addr] <= w_a_wnew;
      if (w_b_wr) mem[b_addr] <= w_b_wnew;
    end
  end

  // Write-first: forward the other port's merged write word on an address hit.
  assign w_a_rdval = ((RDW_MODE == RDW_WRITE_FIRST) && w_b_wr && (b_addr == a_addr))
                     ? w_b_wnew : w_a_old;
  assign w_b_rdval = ((RDW_MODE == RDW_WRITE_FIRST) && w_a_wr && (a_addr == b_addr))
                     ? w_a_wnew : w_b_old;

  dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_a_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_a_rd),
    .in_data   (w_a_rdval),
    .out_valid (a_rvalid),
    .out_data  (a_rdata)
  );

  dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_b_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_b_rd),
    .in_data   (w_b_rdval),
    .out_valid (b_rvalid),
    .out_data  (b_rdata)
  );

`ifdef DPRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_cnt <= '0;
      acc_cnt  <= '0;
    end else begin
      if (coll && (coll_cnt != 16'hFFFF)) coll_cnt <= coll_cnt + 16'd1;
      acc_cnt <= acc_cnt + 32'(a_gnt) + 32'(b_gnt);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_arb
// Purpose  : Self-checking bench for dpram_arb (ADDR_W=6, RD_LAT=2,
//            write-first). A reference model predicts grants/collisions and
//            queues expected read data; a monitor pops it on rvalid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_arb;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = 2;
  localparam int RDW   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]         req   = '0;
  logic [1:0]         we    = '0;
  logic [1:0][AW-1:0] addr  = '0;
  logic [1:0][NB-1:0] be    = '0;
  logic [1:0][DW-1:0] wdata = '0;

  logic          init_busy, coll;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [1:0]         gnt, rvalid;
  logic [1:0][DW-1:0] rdata;
  assign gnt    = {b_gnt, a_gnt};
  assign rvalid = {b_rvalid, a_rvalid};
  assign rdata  = {b_rdata, a_rdata};

`ifdef DPRAM_ARB_STATS_EN
  logic [15:0] coll_cnt;
  logic [31:0] acc_cnt;
`endif

  dpram_arb #(
    .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .RDW_MODE(RDW), .INIT_CLEAR(1)
  ) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_be(be[0]), .a_wdata(wdata[0]),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_be(be[1]), .b_wdata(wdata[1]),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef DPRAM_ARB_STATS_EN
    .coll_cnt(coll_cnt), .acc_cnt(acc_cnt),
`endif
    .coll(coll)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [NB-1:0] be;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  op_t           opq [2][$];
  exp_t          sbq [2][$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] last [2];
  int            cyc = 0;
  int            since_rst = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            exp_acc = 0;
  int            exp_coll = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst) begin
    if (rst) since_rst <= 0;
    else     since_rst <= since_rst + 1;
  end

  // Requester: holds each op until granted, then presents the next one.
  initial begin : driver
    logic [1:0] gseen;
    op_t o;
    forever begin
      @(negedge clk);
      gseen = gnt;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (rst) req[p] = 1'b0;
        else if (!req[p] || gseen[p]) begin
          if (opq[p].size() > 0) begin
            o        = opq[p].pop_front();
            req[p]   = o.req;
            we[p]    = o.we;
            addr[p]  = o.addr;
            be[p]    = o.be;
            wdata[p] = o.wdata;
          end else begin
            req[p] = 1'b0;
          end
        end
      end
    end
  end

  // Reference model: array semantics straight from the port rules.
  always @(negedge clk) begin : model
    logic          rdy, stall;
    logic [1:0]    g;
    logic [DW-1:0] old [2];
    logic [DW-1:0] nw  [2];
    logic [DW-1:0] rd;
    int            q;
    if (rst) begin
      check("rst_gnt",    64'(gnt),       64'(0));
      check("rst_coll",   64'(coll),      64'(0));
      check("rst_rvalid", 64'(rvalid),    64'(0));
      check("rst_rdata",  64'(rdata),     64'(0));
      check("rst_busy",   64'(init_busy), 64'(1));
`ifdef DPRAM_ARB_STATS_EN
      check("rst_coll_cnt", 64'(coll_cnt), 64'(0));
      check("rst_acc_cnt",  64'(acc_cnt),  64'(0));
`endif
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      sbq[0].delete();
      sbq[1].delete();
      exp_acc  = 0;
      exp_coll = 0;
    end else begin
      rdy   = (since_rst >= DEPTH);
      check("init_busy", 64'(init_busy), 64'(!rdy));
      stall = rdy && req[0] && req[1] && we[0] && we[1] && (addr[0] == addr[1]);
      g[0]  = rdy && req[0];
      g[1]  = rdy && req[1] && !stall;
      check("a_gnt", 64'(a_gnt), 64'(g[0]));
      check("b_gnt", 64'(b_gnt), 64'(g[1]));
      check("coll",  64'(coll),  64'(stall));
      for (int p = 0; p < 2; p++) begin
        old[p] = mdl[addr[p]];
        nw[p]  = merge(old[p], wdata[p], be[p]);
      end
      for (int p = 0; p < 2; p++) begin
        if (g[p] && !we[p]) begin
          q  = 1 - p;
          rd = (RDW == 1 && g[q] && we[q] && addr[q] == addr[p]) ? nw[q] : old[p];
          sbq[p].push_back('{rd, cyc + LAT});
        end
      end
      for (int p = 0; p < 2; p++) if (g[p] && we[p]) mdl[addr[p]] = nw[p];
      exp_acc  += int'(g[0]) + int'(g[1]);
      exp_coll += int'(stall);
    end
  end

  // Monitor: rvalid must appear exactly when the oldest expected read is due.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ev;
    if (rst) begin
      last[0] = '0;
      last[1] = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        ev = (sbq[p].size() > 0) && (sbq[p][0].due == cyc);
        check(p ? "b_rvalid" : "a_rvalid", 64'(rvalid[p]), 64'(ev));
        if (ev) begin
          e = sbq[p].pop_front();
          if (rvalid[p]) check(p ? "b_rdata" : "a_rdata", 64'(rdata[p]), 64'(e.data));
          last[p] = e.data;
        end else if (!rvalid[p]) begin
          check(p ? "b_rdata_hold" : "a_rdata_hold", 64'(rdata[p]), 64'(last[p]));
        end
      end
    end
  end

  task automatic push(input int p, input logic r, input logic w, input int a,
                      input logic [NB-1:0] m, input logic [DW-1:0] d);
    opq[p].push_back('{r, w, AW'(a), m, d});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((opq[0].size() + opq[1].size() + sbq[0].size() + sbq[1].size() != 0 || req != 2'b00)
           && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain", 64'(opq[0].size() + opq[1].size() + sbq[0].size() + sbq[1].size()), 64'(0));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    opq[0].delete();
    opq[1].delete();
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reads queued during the clear must wait, then return zero.
    push(0, 1, 0, 3, '0, '0);
    push(1, 1, 0, DEPTH - 1, '0, '0);
    wait_idle(500);

    // Byte-enable merge.
    push(0, 1, 1, 'h10, 4'b1111, 32'hDEADBEEF);
    push(0, 1, 1, 'h10, 4'b0001, 32'h00000055);
    wait_idle(100);
    push(1, 1, 0, 'h10, '0, '0);
    wait_idle(100);

    // Same-address write collision, then read back B's data.
    push(0, 1, 1, 'h20, 4'hF, 32'h11111111);
    push(1, 1, 1, 'h20, 4'hF, 32'h22222222);
    wait_idle(100);
    push(0, 1, 0, 'h20, '0, '0);
    wait_idle(100);

    // Read during write at the same address.
    push(0, 1, 1, 'h30, 4'hF, 32'hAAAA0000);
    wait_idle(100);
    push(0, 1, 1, 'h30, 4'hF, 32'hBBBB1111);
    push(1, 1, 0, 'h30, '0, '0);
    wait_idle(100);

    // Back-to-back reads 0..7.
    for (int i = 0; i < 8; i++) push(0, 1, 0, i, '0, '0);
    wait_idle(100);

    // Reset with a read in flight.
    push(0, 1, 0, 'h10, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_gnt && n < 50);
    check("inflight_gnt", 64'(a_gnt), 64'(1));
    @(posedge clk);
    #1;
    do_reset(2);
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of the clear (clear address 5).
    do_reset(2);
    repeat (5) @(posedge clk);
    #1;
    do_reset(2);
    push(0, 1, 0, 'h10, '0, '0);
    push(1, 1, 0, 'h30, '0, '0);
    wait_idle(500);

    // Randomised traffic on a small address window to provoke collisions.
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) == 0)
          push(p, 0, 0, 0, '0, '0);
        else
          push(p, 1, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 3),
               NB'($urandom), $urandom);
      end
    end
    wait_idle(5000);
    repeat (2) @(posedge clk);
    #1;

`ifdef DPRAM_ARB_STATS_EN
    check("acc_cnt",  64'(acc_cnt),  64'(exp_acc));
    check("coll_cnt", 64'(coll_cnt), 64'((exp_coll > 65535) ? 65535 : exp_coll));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
